serial_pair_scheduler: RTL

//  Shares one bit-serial two-line datapath (LINE1/LINE2 in, OUTP_REG/OVERFLW_REG out) among NUM_REQ requesters.

---
 rtl/serial_sched_pkg.sv | 21 ++
 rtl/serial_sched_arb.sv | 60 ++++++
 rtl/serial_pair_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serial_sched_pkg.sv
// serial_sched_pkg: shared types and width helpers for the serial pair scheduler.
package serial_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Width of a requester index.
   function automatic int id_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Width of the bit counter; one spare bit so it never wraps inside a transaction.
   function automatic int cnt_w(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_sched_arb.sv
// serial_sched_arb: picks one requester and reports it as one-hot plus index.
// Build option SERIAL_SCHED_RR_EN: round-robin search starting at a pointer
// register; without it, fixed priority (lowest index wins) and no pointer.
module serial_sched_arb
   import serial_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
`ifdef SERIAL_SCHED_RR_EN
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     advance,
`endif
   input  logic [NUM_REQ-1:0]       req,
   output logic [NUM_REQ-1:0]       grant,
   output logic [id_w(NUM_REQ)-1:0] grant_id
);

   localparam int ID_W = id_w(NUM_REQ);

   logic [ID_W-1:0] base;
   logic            found;
   int              idx;

`ifdef SERIAL_SCHED_RR_EN
   logic [ID_W-1:0] ptr;

   // Pointer moves one past the accepted winner so it has lowest priority next time.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   assign base = ptr;
`else
   assign base = '0;
`endif

   // Scan from base upward, wrapping modulo NUM_REQ; first active request wins.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(base) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/serial_pair_scheduler.sv
// serial_pair_scheduler: arbitrates NUM_REQ requesters onto one bit-serial
// two-line datapath, shifts the winner's operand pair out LSB-first, collects
// the serial result RESULT_LAT cycles later and returns it as a parallel word
// tagged with the requester id.
// Build option SERIAL_SCHED_RR_EN selects round-robin arbitration (default:
// fixed priority, lowest index wins).
module serial_pair_scheduler
   import serial_sched_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 8,
   parameter int RESULT_LAT = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     line1,
   output logic                     line2,
   input  logic                     outp_in,
   input  logic                     overflw_in,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [id_w(NUM_REQ)-1:0] rsp_id,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_ovf,
   output logic                     busy
);

   localparam int ID_W  = id_w(NUM_REQ);
   localparam int CNT_W = cnt_w(WIDTH);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [WIDTH-1:0]      a_sh;
   logic [WIDTH-1:0]      b_sh;
   logic [WIDTH-1:0]      op_a;
   logic [WIDTH-1:0]      op_b;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       grant_id;
   logic                  accept;
   logic [RESULT_LAT-1:0] cap_pipe;
   logic                  take;

   serial_sched_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
`ifdef SERIAL_SCHED_RR_EN
      .clock    (clock),
      .reset    (reset),
      .advance  (accept),
`endif
      .req      (req_valid),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign accept = (state == IDLE) && (|req_valid);
   assign op_a   = req_a[int'(grant_id) * WIDTH +: WIDTH];
   assign op_b   = req_b[int'(grant_id) * WIDTH +: WIDTH];

   // Grant is only offered while idle and out of reset, so every output reads 0 under reset.
   assign req_ready = (state == IDLE && reset) ? grant : '0;

   // Transaction FSM: latch winner, shift operands out, wait for capture, hold response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         line1     <= 1'b0;
         line2     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         busy      <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         case (state)
            IDLE: begin
               if (accept) begin
                  state  <= SHIFT;
                  busy   <= 1'b1;
                  rsp_id <= grant_id;
                  cnt    <= '0;
                  line1  <= op_a[0];
                  line2  <= op_b[0];
                  a_sh   <= op_a >> 1;
                  b_sh   <= op_b >> 1;
               end
            end
            SHIFT: begin
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= DRAIN;
                  cnt   <= '0;
                  line1 <= 1'b0;
                  line2 <= 1'b0;
               end else begin
                  cnt   <= cnt + 1'b1;
                  line1 <= a_sh[0];
                  line2 <= b_sh[0];
                  a_sh  <= a_sh >> 1;
                  b_sh  <= b_sh >> 1;
               end
            end
            DRAIN: begin
               if (cnt == CNT_W'(RESULT_LAT - 1)) begin
                  state     <= RESP;
                  cnt       <= '0;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // A bit driven in SHIFT reaches the end of cap_pipe exactly RESULT_LAT cycles later.
   assign take = cap_pipe[RESULT_LAT-1];

   // Capture: delay the "bit on the lines" flag, then shift outp_in in from the MSB
   // so the first sample ends up in bit 0; overflow is the OR over the same samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cap_pipe <= '0;
         rsp_data <= '0;
         rsp_ovf  <= 1'b0;
      end else begin
         cap_pipe <= RESULT_LAT'({cap_pipe, (state == SHIFT)});
         if (accept) begin
            rsp_data <= '0;
            rsp_ovf  <= 1'b0;
         end else if (take) begin
            rsp_data <= {outp_in, rsp_data[WIDTH-1:1]};
            rsp_ovf  <= rsp_ovf | overflw_in;
         end
      end
   end

endmodule
